// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array: sequencer states and phase lengths.
package sa_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StCompute,
    StDrain,
    StFin
  } sa_state_e;

  localparam int unsigned DefRows = 4;
  localparam int unsigned DefCols = 4;

  // Each chain hop costs two array cycles, so the last row needs 2*rows-1 slots.
  function automatic int unsigned load_cyc(int unsigned rows);
    return 2 * rows - 1;
  endfunction

  function automatic int unsigned drain_cyc(int unsigned rows, int unsigned cols);
    return rows + cols - 1;
  endfunction

  localparam int unsigned LoadCyc  = load_cyc(DefRows);
  localparam int unsigned DrainCyc = drain_cyc(DefRows, DefCols);

endpackage

// File: rtl/sa_valid_pipe.sv
// Valid-token shift register that tracks vectors through the array; taps give per-column strobes.
module sa_valid_pipe #(
  parameter int unsigned Depth   = 8,
  parameter int unsigned Cols    = 4,
  parameter int unsigned TapBase = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            token_i,
  output logic [Cols-1:0] valid_o
);

  logic [Depth-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d = {stage_q[Depth-2:0], token_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q[TapBase +: Cols];

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for the weight-stationary PE array: weight load, ifmap streaming, drain.
module systolic_array_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned Rows  = DefRows,
  parameter int unsigned Cols  = DefCols,
  parameter int unsigned VecW  = 16,
  parameter int unsigned RdLat = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [VecW-1:0]         num_vecs_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wbuf_rd_en_o,
  output logic [$clog2(Rows)-1:0] wbuf_rd_addr_o,
  output logic                    ibuf_rd_en_o,
  output logic [VecW-1:0]         ibuf_rd_addr_o,
  output logic                    arr_en_o,
  output logic                    arr_load_weight_o,
  output logic                    arr_wdata_zero_o,
  output logic [Cols-1:0]         ofmap_valid_o,
  input  logic                    out_ready_i
);

  localparam int unsigned IssueLen = load_cyc(Rows);
  // LOAD_W also covers the read-latency tail so COMPUTE never overlaps load mode.
  localparam int unsigned LoadLen  = IssueLen + RdLat;
  localparam int unsigned DrainLen = drain_cyc(Rows, Cols);
  localparam int unsigned PhW      = $clog2(LoadLen + DrainLen);
  localparam int unsigned AddrW    = $clog2(Rows);

  sa_state_e        state_q, state_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [VecW-1:0]  vcnt_q, vcnt_d;
  logic [VecW-1:0]  nv_q, nv_d;
  logic [RdLat-1:0] ld_q;
  logic [RdLat-1:0] gap_q;

  logic issue;
  logic gap;
  logic streaming;
  logic frozen;

  assign streaming = (state_q == StCompute) || (state_q == StDrain);
  assign frozen    = streaming && !out_ready_i;

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    vcnt_d         = vcnt_q;
    nv_d           = nv_q;
    issue          = 1'b0;
    gap            = 1'b0;
    busy_o         = (state_q != StIdle);
    done_o         = 1'b0;
    wbuf_rd_en_o   = 1'b0;
    wbuf_rd_addr_o = '0;
    ibuf_rd_en_o   = 1'b0;
    ibuf_rd_addr_o = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoadW;
          ph_d    = '0;
          vcnt_d  = '0;
          nv_d    = num_vecs_i;
        end
      end

      StLoadW: begin
        if (ph_q < PhW'(IssueLen)) begin
          issue = 1'b1;
          // Even slots feed rows bottom-up; odd slots are gaps filled with zero.
          if (!ph_q[0]) begin
            wbuf_rd_en_o   = 1'b1;
            wbuf_rd_addr_o = AddrW'(Rows - 1) - AddrW'(ph_q >> 1);
          end else begin
            gap = 1'b1;
          end
        end
        if (ph_q == PhW'(LoadLen - 1)) begin
          ph_d    = '0;
          state_d = (nv_q == '0) ? StFin : StCompute;
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end

      StCompute: begin
        ibuf_rd_addr_o = vcnt_q;
        if (out_ready_i) begin
          ibuf_rd_en_o = 1'b1;
          vcnt_d       = vcnt_q + VecW'(1);
          if (vcnt_q == nv_q - VecW'(1)) begin
            state_d = StDrain;
            ph_d    = '0;
          end
        end
      end

      StDrain: begin
        if (out_ready_i) begin
          if (ph_q == PhW'(DrainLen - 1)) begin
            state_d = StFin;
          end else begin
            ph_d = ph_q + PhW'(1);
          end
        end
      end

      StFin: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ph_q    <= '0;
      vcnt_q  <= '0;
      nv_q    <= '0;
      ld_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      vcnt_q   <= vcnt_d;
      nv_q     <= nv_d;
      ld_q[0]  <= issue;
      gap_q[0] <= gap;
      for (int i = 1; i < RdLat; i++) begin
        ld_q[i]  <= ld_q[i-1];
        gap_q[i] <= gap_q[i-1];
      end
    end
  end

  // Load strobes and gap zeroing line up with the buffer data, RdLat after issue.
  assign arr_load_weight_o = ld_q[RdLat-1];
  assign arr_wdata_zero_o  = gap_q[RdLat-1];
  assign arr_en_o          = ld_q[RdLat-1] | (streaming & out_ready_i);

  // Pipe advances whenever not frozen so the last token leaves during FIN.
  sa_valid_pipe #(
    .Depth  (RdLat + Rows + Cols - 1),
    .Cols   (Cols),
    .TapBase(RdLat + Rows - 1)
  ) u_valid_pipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (!frozen),
    .token_i(ibuf_rd_en_o),
    .valid_o(ofmap_valid_o)
  );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl (4x4, read latency 1) with a behavioural weight chain.
module tb_systolic_array_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [15:0] num_vecs_i;
  logic        busy_o;
  logic        done_o;
  logic        wbuf_rd_en_o;
  logic [1:0]  wbuf_rd_addr_o;
  logic        ibuf_rd_en_o;
  logic [15:0] ibuf_rd_addr_o;
  logic        arr_en_o;
  logic        arr_load_weight_o;
  logic        arr_wdata_zero_o;
  logic [3:0]  ofmap_valid_o;
  logic        out_ready_i;

  int checks = 0;
  int errors = 0;

  systolic_array_ctrl #(
    .Rows (4),
    .Cols (4),
    .VecW (16),
    .RdLat(1)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .num_vecs_i       (num_vecs_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .wbuf_rd_en_o     (wbuf_rd_en_o),
    .wbuf_rd_addr_o   (wbuf_rd_addr_o),
    .ibuf_rd_en_o     (ibuf_rd_en_o),
    .ibuf_rd_addr_o   (ibuf_rd_addr_o),
    .arr_en_o         (arr_en_o),
    .arr_load_weight_o(arr_load_weight_o),
    .arr_wdata_zero_o (arr_wdata_zero_o),
    .ofmap_valid_o    (ofmap_valid_o),
    .out_ready_i      (out_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural weight buffer (row r holds 0xA0+r) and 8-register daisy chain.
  logic [7:0] wdata_q;
  logic [7:0] chain [8];

  always @(posedge clk_i) begin
    if (rst_i) begin
      wdata_q <= 8'h00;
      for (int p = 0; p < 8; p++) chain[p] <= 8'h00;
    end else begin
      if (wbuf_rd_en_o) wdata_q <= 8'(160 + int'(wbuf_rd_addr_o));
      if (arr_en_o && arr_load_weight_o) begin
        chain[0] <= arr_wdata_zero_o ? 8'h00 : wdata_q;
        for (int p = 1; p < 8; p++) chain[p] <= chain[p-1];
      end
    end
  end

  function automatic logic [28:0] obs();
    return {busy_o, done_o, wbuf_rd_en_o, wbuf_rd_addr_o, ibuf_rd_en_o, ibuf_rd_addr_o,
            arr_en_o, arr_load_weight_o, arr_wdata_zero_o, ofmap_valid_o};
  endfunction

  // Expected outputs e cycles after an accepted start, for an unstalled tile of nv vectors.
  function automatic logic [28:0] timeline(int e, int nv);
    int cs, fin, d;
    logic busy, dn, wen, ien, aen, lw, z;
    logic [1:0]  wa;
    logic [15:0] ia;
    logic [3:0]  ov;
    cs   = 8;
    fin  = (nv == 0) ? 8 : cs + nv + 7;
    busy = (e <= fin);
    dn   = (e == fin);
    wen  = (e < 7) && (e % 2 == 0);
    wa   = wen ? 2'(3 - e / 2) : 2'd0;
    lw   = (e >= 1) && (e <= 7);
    z    = (e == 2) || (e == 4) || (e == 6);
    ien  = (e >= cs) && (e < cs + nv);
    ia   = ien ? 16'(e - cs) : 16'd0;
    aen  = lw || ((e >= cs) && (e < fin));
    for (int c = 0; c < 4; c++) begin
      d     = e - cs - 5 - c;
      ov[c] = (d >= 0) && (d < nv);
    end
    return {busy, dn, wen, wa, ien, ia, aen, lw, z, ov};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic launch(input int nv);
    start_i    = 1'b1;
    num_vecs_i = 16'(nv);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Follows a tile from cycle 0 to the idle cycle after done. out_ready is low for
  // cycles 9..9+stall-1; start is pulsed (and ignored) at cycle ign_at.
  task automatic follow(input int nv, input int stall, input int ign_at, input string tag);
    int fin, last, e;
    logic [28:0] exp;
    fin  = (nv == 0) ? 8 : 15 + nv;
    last = fin + stall + 1;
    for (int c = 0; c <= last; c++) begin
      out_ready_i = !(c >= 9 && c < 9 + stall);
      start_i     = (c == ign_at);
      if (c == ign_at) num_vecs_i = 16'd7;
      #1;
      if (c < 9) begin
        exp = timeline(c, nv);
      end else if (c < 9 + stall) begin
        // Frozen after the first read: busy, address held at 1, nothing else.
        exp = {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'd1, 1'b0, 1'b0, 1'b0, 4'd0};
      end else begin
        e   = c - stall;
        exp = timeline(e, nv);
      end
      chk(tag, c, 32'(obs()), 32'(exp));
      if (c < last) begin
        @(posedge clk_i);
        #1;
      end
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
  endtask

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    num_vecs_i  = 16'd0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset", 0, 32'(obs()), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Clean tile; a start during COMPUTE must be ignored.
    launch(3);
    follow(3, 0, 10, "tile_a");
    for (int r = 0; r < 4; r++) chk("weight_reg", r, 32'(chain[2*r]), 32'(160 + r));
    for (int r = 0; r < 3; r++) chk("weight_out_gap", r, 32'(chain[2*r+1]), 32'd0);

    // Start on the cycle after done: identical timing.
    launch(3);
    follow(3, 0, -1, "back_to_back");

    // Three frozen cycles mid-COMPUTE shift everything after by exactly three.
    launch(3);
    follow(3, 3, -1, "stall");

    // Weight load only; a start coinciding with done is ignored.
    launch(0);
    follow(0, 0, 8, "nv_zero");

    // Reset during LOAD_W aborts with no done, then a clean tile runs.
    launch(3);
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_abort", 0, 32'(obs()), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_idle", 1, 32'(obs()), 32'd0);
    launch(2);
    follow(2, 0, -1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
